// File: rtl/ysyx_25060173_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one word read at a time
// and hands the returned instruction to the core over a valid/ready pair.
module ysyx_25060173_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     fetch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_drop;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic [31:0]     r_cnt;
  logic            r_req_valid;
  logic            r_inst_valid;

  logic [XLEN-1:0] w_redir_pc;
  logic [XLEN-1:0] w_pc_inc;

  assign w_redir_pc = redirect_pc & ~XLEN'(3);
  assign w_pc_inc   = r_pc + XLEN'(4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pc         <= XLEN'(RESET_PC);
      r_drop       <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_cnt        <= '0;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
    end else begin
      if (redirect_valid) r_pc <= w_redir_pc;
      unique case (r_state)
        S_IDLE: begin
          if (!redirect_valid) begin
            r_state     <= S_REQ;
            r_req_valid <= 1'b1;
          end
        end
        S_REQ: begin
          // an accepted address that a redirect just overtook is stale
          if (req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
            r_drop      <= redirect_valid;
          end
        end
        S_WAIT: begin
          if (rsp_valid) begin
            if (r_drop || redirect_valid) begin
              r_drop      <= 1'b0;
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_inst       <= rsp_data;
              r_inst_pc    <= r_pc;
              r_state      <= S_HOLD;
              r_inst_valid <= 1'b1;
            end
          end else if (redirect_valid) begin
            r_drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            r_state      <= S_REQ;
            r_inst_valid <= 1'b0;
            r_req_valid  <= 1'b1;
          end else if (inst_ready) begin
            r_pc         <= w_pc_inc;
            r_cnt        <= r_cnt + 32'd1;
            r_state      <= S_REQ;
            r_inst_valid <= 1'b0;
            r_req_valid  <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_req_valid  <= 1'b0;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_valid  = r_req_valid;
  assign req_addr   = r_pc;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign fetch_cnt  = r_cnt;

endmodule
